// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl -- load/store unit between the core data port and a word bus.
//
// Takes one memory op from the core and runs it as a single word-aligned bus
// transaction using a valid/ready handshake. The core is stalled while the
// transaction is in flight. Stores get byte-lane steering and write strobes.
// Loads are extracted from the returned word and sign- or zero-extended.
// An access that waits too long on the bus is aborted with err.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid, memop, wen,   core request (memop: 000 B, 001 H, 010 W,
//   addr, wdata                100 BU, 101 HU; wdata right-aligned)
//   stall                    core must hold PC and request inputs
//   resp_valid, rdata, err   one-cycle completion pulse, load data, abort flag
//   bus_valid/bus_ready      request handshake
//   bus_addr, bus_wen,       word address, write enable,
//   bus_wstrb, bus_wdata       byte strobes, lane-steered data
//   bus_rvalid, bus_rdata    read return
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to abort misaligned
// half/word accesses with err and no bus traffic. When it is undefined,
// misaligned accesses ignore the low address bits.

module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  memop,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic        bus_wen,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYC);

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               wen_q, wen_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               legal_op;
    logic               misalign;
    logic [CNT_W:0]     cnt_inc;
    logic               to_hit;
    logic [3:0]         strb;
    logic [31:0]        wd_steer;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data;
    logic               in_req;

    // ------------------------------------------------------------------
    // Request decode (on the live inputs, used in IDLE)
    // ------------------------------------------------------------------
    // The unsigned variants exist only for loads, so a store with
    // memop 100/101 is treated as illegal.
    always_comb begin
        case (memop)
            3'b000, 3'b001, 3'b010: legal_op = 1'b1;
            3'b100, 3'b101:         legal_op = ~wen;
            default:                legal_op = 1'b0;
        endcase
    end

    // memop[1:0]: 01 = half, 10 = word
    assign misalign = ((memop[1:0] == 2'b01) && addr[0]) ||
                      ((memop[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // ------------------------------------------------------------------
    // Timeout: the counter counts the cycles already spent in REQ/WAIT. The
    // access aborts at the end of the cycle that would bring the count to
    // TIMEOUT_CYC. A completion in that same cycle still takes priority.
    // ------------------------------------------------------------------
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign to_hit  = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);

    // ------------------------------------------------------------------
    // Store lane steering from the captured request
    // ------------------------------------------------------------------
    always_comb begin
        strb     = 4'b1111;
        wd_steer = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                strb     = 4'b0001 << addr_q[1:0];
                wd_steer = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb     = 4'b0011 << {addr_q[1], 1'b0};
                wd_steer = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction; op_q[2] set means zero-extend
    // ------------------------------------------------------------------
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = bus_rdata[7:0];
            2'b01:   ld_byte = bus_rdata[15:8];
            2'b10:   ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ld_data = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~op_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs are driven only in REQ, so they read zero when idle
    // ------------------------------------------------------------------
    assign in_req     = (state_q == REQ);
    assign bus_valid  = in_req;
    assign bus_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wen    = in_req & wen_q;
    assign bus_wstrb  = (in_req & wen_q) ? strb : 4'h0;
    assign bus_wdata  = (in_req & wen_q) ? wd_steer : 32'h0;

    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign err        = err_q;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall   = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated with rst so that stall reads 0 while the block is in reset.
                stall = req_valid & rst;
                if (req_valid) begin
                    op_d    = memop;
                    wen_d   = wen;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (!legal_op) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
`endif
                    else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                cnt_d = cnt_inc[CNT_W-1:0];
                if (bus_ready) begin
                    if (wen_q) begin
                        state_d = RESP;
                        err_d   = 1'b0;
                    end else if (bus_rvalid) begin
                        state_d = RESP;
                        rdata_d = ld_data;
                        err_d   = 1'b0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end else if (to_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_inc[CNT_W-1:0];
                if (bus_rvalid) begin
                    state_d = RESP;
                    rdata_d = ld_data;
                    err_d   = 1'b0;
                end else if (to_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The misalign decode is only consumed when the trap is built in.
    logic unused_ok;
    assign unused_ok = misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;

    logic        clk, rst;
    logic        req_valid, wen, bus_ready, bus_rvalid;
    logic [2:0]  memop;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, resp_valid, err, bus_valid, bus_wen;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    int total = 0;
    int passed = 0;
    int fails = 0;

    lsu_bus_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .memop(memop), .wen(wen),
        .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid),
        .rdata(rdata), .err(err), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        req_valid = 1'b1;
        memop     = op;
        wen       = w;
        addr      = a;
        wdata     = d;
    endtask

    // Load with rdly REQ cycles before ready, rvalid one cycle after accept.
    task automatic load(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] word, input int rdly, input logic [31:0] exp);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        req(op, 1'b0, a, 32'h0);
        bus_ready = 1'b0;
        tick();
        chk({tag, " bus_addr"}, bus_addr, wa);
        for (int i = 0; i < rdly; i++) begin
            chk({tag, " stall"}, {31'h0, stall}, 32'h1);
            chk({tag, " bus_valid"}, {31'h0, bus_valid}, 32'h1);
            tick();
        end
        bus_ready = 1'b1;
        tick();
        bus_ready  = 1'b0;
        chk({tag, " wait bus_valid"}, {31'h0, bus_valid}, 32'h0);
        chk({tag, " wait stall"}, {31'h0, stall}, 32'h1);
        bus_rvalid = 1'b1;
        bus_rdata  = word;
        tick();
        bus_rvalid = 1'b0;
        chk({tag, " resp_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " err"}, {31'h0, err}, 32'h0);
        req_valid = 1'b0;
        tick();
        chk({tag, " resp done"}, {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        req_valid = 0; memop = 0; wen = 0; addr = 0; wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(); tick();
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst err", {31'h0, err}, 32'h0);
        chk("rst bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        rst = 1'b1;
        tick();

        // SB 0x1003, zero-wait
        req(3'b000, 1'b1, 32'h1003, 32'hAB);
        bus_ready = 1'b1;
        #1 chk("sb idle stall", {31'h0, stall}, 32'h1);
        tick();
        chk("sb bus_valid", {31'h0, bus_valid}, 32'h1);
        chk("sb bus_addr", bus_addr, 32'h1000);
        chk("sb wstrb", {28'h0, bus_wstrb}, 32'h8);
        chk("sb wdata", bus_wdata, 32'hABABABAB);
        chk("sb bus_wen", {31'h0, bus_wen}, 32'h1);
        chk("sb early resp", {31'h0, resp_valid}, 32'h0);
        tick();
        chk("sb resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sb err", {31'h0, err}, 32'h0);
        chk("sb resp stall", {31'h0, stall}, 32'h0);
        chk("sb resp bus_valid", {31'h0, bus_valid}, 32'h0);
        req_valid = 1'b0; bus_ready = 1'b0;
        tick();
        chk("sb resp pulse", {31'h0, resp_valid}, 32'h0);

        load("lb",  3'b000, 32'h2001, 32'h00008000, 0, 32'hFFFFFF80);
        load("lbu", 3'b100, 32'h2001, 32'h00008000, 0, 32'h00000080);
        load("lh",  3'b001, 32'h2002, 32'h87654321, 2, 32'hFFFF8765);
        load("lhu", 3'b101, 32'h2000, 32'h1234F00D, 1, 32'h0000F00D);

        // LW timeout after 4 REQ cycles
        req(3'b010, 1'b0, 32'h4000, 32'h0);
        tick();
        chk("to bus_valid", {31'h0, bus_valid}, 32'h1);
        tick(); tick(); tick();
        chk("to 4th req bus_valid", {31'h0, bus_valid}, 32'h1);
        chk("to 4th req resp", {31'h0, resp_valid}, 32'h0);
        tick();
        chk("to resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("to err", {31'h0, err}, 32'h1);
        chk("to rdata", rdata, 32'h0);
        chk("to bus_valid off", {31'h0, bus_valid}, 32'h0);
        req_valid = 1'b0;
        tick();
        chk("to after resp", {31'h0, resp_valid}, 32'h0);
        chk("to err held", {31'h0, err}, 32'h1);

        // Illegal memop
        req(3'b011, 1'b0, 32'h5000, 32'h0);
        tick();
        chk("ill bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("ill resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("ill err", {31'h0, err}, 32'h1);
        req_valid = 1'b0;
        tick();

        // SW clears err; store leaves rdata alone
        req(3'b010, 1'b1, 32'h6000, 32'hDEADBEEF);
        bus_ready = 1'b1;
        tick();
        chk("sw wstrb", {28'h0, bus_wstrb}, 32'hF);
        chk("sw wdata", bus_wdata, 32'hDEADBEEF);
        tick();
        chk("sw resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sw err cleared", {31'h0, err}, 32'h0);
        chk("sw rdata held", rdata, 32'h0);
        req_valid = 1'b0; bus_ready = 1'b0;
        tick();

`ifdef LSU_MISALIGN_TRAP_EN
        req(3'b010, 1'b0, 32'h3002, 32'h0);
        tick();
        chk("mis bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("mis resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("mis err", {31'h0, err}, 32'h1);
        chk("mis rdata", rdata, 32'h0);
        req_valid = 1'b0;
        tick();
`else
        req(3'b001, 1'b1, 32'h1001, 32'h1234);
        bus_ready = 1'b1;
        tick();
        chk("sh mis wstrb", {28'h0, bus_wstrb}, 32'h3);
        chk("sh mis wdata", bus_wdata, 32'h12341234);
        chk("sh mis addr", bus_addr, 32'h1000);
        tick();
        chk("sh mis err", {31'h0, err}, 32'h0);
        req_valid = 1'b0; bus_ready = 1'b0;
        tick();
        load("lw mis", 3'b010, 32'h3002, 32'h11223344, 0, 32'h11223344);
`endif

        // Reset while in WAIT
        req(3'b010, 1'b0, 32'h7000, 32'h0);
        bus_ready = 1'b1;
        tick();
        tick();
        bus_ready = 1'b0;
        chk("rw in wait", {31'h0, stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rw stall", {31'h0, stall}, 32'h0);
        chk("rw bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rw resp_valid", {31'h0, resp_valid}, 32'h0);
        req_valid  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFEF00D;
        rst = 1'b1;
        tick();
        chk("rw late rvalid", {31'h0, resp_valid}, 32'h0);
        bus_rvalid = 1'b0;
        tick();
        chk("rw idle resp", {31'h0, resp_valid}, 32'h0);
        chk("rw idle stall", {31'h0, stall}, 32'h0);
        chk("rw rdata", rdata, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
